// File: rtl/inst_cache_pkg.sv
// Shared widths, address-split constants and FSM encoding for the instruction cache.
package inst_cache_pkg;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned INST_WIDTH  = 32;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned NUM_LINES   = 64;

    localparam int unsigned OFFSET_BITS = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
    localparam int unsigned LINE_LSB    = OFFSET_BITS + 2;
    localparam int unsigned TAG_BITS    = ADDR_WIDTH - INDEX_BITS - LINE_LSB;
    localparam int unsigned RAM_AW      = INDEX_BITS + OFFSET_BITS;
    localparam int unsigned RAM_DEPTH   = NUM_LINES * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side signal bundle; slave is the cache, master drives it.
interface inst_cache_if;
    import inst_cache_pkg::*;

    logic                  cpu_ce;
    logic                  cpu_stall;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_flush;
    logic                  cpu_inst_enable;
    logic [INST_WIDTH-1:0] cpu_inst;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_valid;
    logic [INST_WIDTH-1:0] mem_data;

    modport slave (
        input  cpu_ce, cpu_stall, cpu_addr, cpu_flush,
        output cpu_inst_enable, cpu_inst,
        output mem_req, mem_addr,
        input  mem_ready, mem_valid, mem_data
    );

    modport master (
        output cpu_ce, cpu_stall, cpu_addr, cpu_flush,
        input  cpu_inst_enable, cpu_inst,
        input  mem_req, mem_addr,
        output mem_ready, mem_valid, mem_data
    );

endinterface

// File: rtl/inst_cache_ram.sv
// Line data store: one registered read port (held when not enabled) and one write port.
module inst_cache_ram
    import inst_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   re,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_word,
    input  logic                   we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_word,
    input  logic [INST_WIDTH-1:0]  wr_data,
    output logic [INST_WIDTH-1:0]  rd_data
);

    logic [INST_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [INST_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [RAM_AW-1:0]     rd_addr, wr_addr;

    assign rd_addr = {rd_index, rd_word};
    assign wr_addr = {wr_index, wr_word};

    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array carries no reset; validity is tracked in the tag side.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: one-cycle hits, whole-line refill over a word-wide memory port.
module inst_cache
    import inst_cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus
);

    state_e                 state_q, state_d;
    logic                   en_q, en_d;
    logic                   req_q, req_d;
    logic [ADDR_WIDTH-1:0]  line_q, line_d;
    logic [OFFSET_BITS-1:0] beat_q, beat_d;
    logic                   flushed_q, flushed_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q [NUM_LINES];

    logic [OFFSET_BITS-1:0] cpu_word;
    logic [INDEX_BITS-1:0]  cpu_index, fill_index;
    logic [TAG_BITS-1:0]    cpu_tag, fill_tag;
    logic [1:0]             unused_byte_bits;
    logic                   hit;
    logic                   tag_we, ram_we, ram_re;
    logic [INST_WIDTH-1:0]  ram_rd_data;

    assign cpu_word         = bus.cpu_addr[LINE_LSB-1:2];
    assign cpu_index        = bus.cpu_addr[LINE_LSB +: INDEX_BITS];
    assign cpu_tag          = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_byte_bits = bus.cpu_addr[1:0];
    assign fill_index       = line_q[LINE_LSB +: INDEX_BITS];
    assign fill_tag         = line_q[ADDR_WIDTH-1 -: TAG_BITS];

    assign hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        req_d     = req_q;
        line_d    = line_q;
        beat_d    = beat_q;
        flushed_d = flushed_q | bus.cpu_flush;
        valid_d   = valid_q;
        tag_we    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;

        if (bus.cpu_flush) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (!bus.cpu_stall) begin
                    if (!bus.cpu_ce) begin
                        en_d = 1'b0;
                    end else begin
                        ram_re = 1'b1;
                        if (hit && !bus.cpu_flush) begin
                            en_d = 1'b1;
                        end else begin
                            en_d      = 1'b0;
                            req_d     = 1'b1;
                            line_d    = {bus.cpu_addr[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
                            flushed_d = 1'b0;
                            state_d   = REQ;
                        end
                    end
                end
            end
            REQ: begin
                en_d = 1'b0;
                if (bus.mem_ready) begin
                    req_d   = 1'b0;
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                en_d = 1'b0;
                if (bus.mem_valid) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + OFFSET_BITS'(1);
                    if (beat_q == OFFSET_BITS'(LINE_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                        // A flush seen anywhere in this refill leaves the line invalid.
                        if (!flushed_q && !bus.cpu_flush) begin
                            valid_d[fill_index] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            req_q     <= 1'b0;
            line_q    <= '0;
            beat_q    <= '0;
            flushed_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            req_q     <= req_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            flushed_q <= flushed_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

    inst_cache_ram u_ram (
        .clk      (clk),
        .rst      (rst),
        .re       (ram_re),
        .rd_index (cpu_index),
        .rd_word  (cpu_word),
        .we       (ram_we),
        .wr_index (fill_index),
        .wr_word  (beat_q),
        .wr_data  (bus.mem_data),
        .rd_data  (ram_rd_data)
    );

    assign bus.cpu_inst_enable = en_q;
    assign bus.cpu_inst        = ram_rd_data;
    assign bus.mem_req         = req_q;
    assign bus.mem_addr        = line_q;

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped instruction cache that responds to the CPU fetch port (PC drives ce/stall/addr; cache returns enable/inst to the Decoder). Hits return in one cycle. Misses refill a whole line from a word-wide memory port using a request/ready handshake followed by valid-qualified data beats. Sits between the CPU top-level fetch interface and the memory/bus arbiter.

Parameters:
ADDR_WIDTH, 32, fetch address width (matches Inst_Addr_Width)
INST_WIDTH, 32, instruction/word width (matches Inst_Width)
LINE_WORDS, 4, words per line (power of 2)
NUM_LINES, 64, number of lines (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_ce  in  1  fetch request valid
cpu_stall  in  1  requester stalled; hold response, no new lookup
cpu_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
cpu_flush  in  1  invalidate all lines
cpu_inst_enable  out  1  cpu_inst valid
cpu_inst  out  INST_WIDTH  fetched instruction
mem_req  out  1  line refill request
mem_addr  out  ADDR_WIDTH  line-aligned refill address
mem_ready  in  1  memory accepts request this cycle
mem_valid  in  1  data beat valid
mem_data  in  INST_WIDTH  refill word; beats are in ascending word order

Behaviour:
- Address split: word offset = addr[log2(LINE_WORDS)+1:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Reset (async): all valid bits = 0; state = IDLE; cpu_inst_enable = 0; cpu_inst = 0; mem_req = 0; mem_addr = 0; beat counter = 0.
- FSM states: IDLE, REQ, FILL.
- IDLE, cpu_stall = 1:
  - cpu_inst_enable and cpu_inst hold their values.
  - No lookup is performed.
- IDLE, cpu_stall = 0, cpu_ce = 0: cpu_inst_enable <= 0.
- IDLE, cpu_stall = 0, cpu_ce = 1, hit (valid and tag match):
  - Next cycle: cpu_inst_enable = 1, cpu_inst = the addressed word. Latency is 1 cycle.
- IDLE, cpu_stall = 0, cpu_ce = 1, miss:
  - cpu_inst_enable <= 0.
  - Latch the line address and go to REQ.
- REQ:
  - mem_req = 1; mem_addr = latched line address with offset bits zero.
  - Stay in REQ until mem_ready = 1 in the same cycle as mem_req; then go to FILL and clear the beat counter.
  - mem_req drops the cycle after acceptance.
- FILL:
  - Each mem_valid = 1 cycle writes mem_data into data[index][beat] and increments the beat counter.
  - On beat LINE_WORDS-1: write tag, set valid (unless a flush occurred during this refill), go to IDLE.
  - mem_valid is ignored outside FILL. Memory returns no data before acceptance.
- During REQ and FILL: cpu_inst_enable = 0; cpu_ce and cpu_addr are ignored.
- Requester protocol: the requester holds cpu_addr and cpu_ce until it sees cpu_inst_enable. After the refill, the held request re-looks-up in IDLE and hits.
- Miss timeline with mem_ready = 1 at once and back-to-back beats:
  - Lookup at cycle 0; REQ at cycle 1; beats at cycles 2–5.
  - IDLE lookup at cycle 6; cpu_inst_enable = 1 at cycle 7.
- cpu_flush:
  - Clears all valid bits in one cycle; takes priority over a same-cycle hit (treated as a miss).
  - If asserted during REQ/FILL, the refill completes on the memory side, but its line is not marked valid.
- Reset mid-refill: the refill is abandoned, mem_req drops immediately, and no line is valid.
- Index aliasing: a refill overwrites the resident line unconditionally.

Decomposition:
- Shared package: ADDR_WIDTH, INST_WIDTH, derived OFFSET_BITS/INDEX_BITS/TAG_BITS, FSM state encoding (IDLE/REQ/FILL).
- Sub-module inst_cache_ram: a NUM_LINES×LINE_WORDS word array with one registered read port and one write port (index, word, data, we).
- Tag/valid arrays and the FSM stay in inst_cache.

Test Plan:
- Cold miss: ce=1, addr=0x0000_0100; mem_ready=1; beats 0x11,0x22,0x33,0x44 on cycles 2–5 → mem_addr=0x100 at cycle 1; cpu_inst_enable=1 with inst=0x11 at cycle 7.
- Hit same line: after the cold miss, addr=0x108 → next cycle enable=1, inst=0x33; mem_req stays 0.
- Stall hold: hit returns 0x22 (addr 0x104); then cpu_stall=1 for 3 cycles with addr changed to 0x10C → enable=1, inst=0x22 held for all 3 cycles; inst=0x44 the cycle after the stall is released.
- Conflict eviction: fill 0x100, then request 0x500 (same index, different tag) → new refill at mem_addr=0x500; a later 0x100 request misses again.
- Delayed handshake: mem_ready low for 5 cycles → mem_req and mem_addr held stable throughout; the fill starts only after acceptance; spurious mem_valid during REQ is ignored.
- Flush/reset: flush during FILL → refill completes, then the same address misses again. rst asserted mid-FILL → mem_req=0 and enable=0 immediately; the next access misses.
